// File: rtl/freq_filter_mul.sv
// ---------------------------------------------------------------------------
// freq_filter_mul
//
// Radial frequency-domain filter for a streamed H x W complex frame.
// The block tracks each pixel's position and computes its squared distance
// from the frame centre. It selects a pass or stop gain from the configured
// mode and radius thresholds. It then scales both complex components by the
// Q1.(GAIN_W-1) gain, with floor rounding and saturation.
//
// The pipeline has three registered stages:
//   stage 1 : position offsets, beat data and per-frame configuration
//   stage 2 : squared distance and gain selection
//   stage 3 : multiply, shift and saturate (this is the output register)
// All stages share one advance enable, so a stalled output freezes the whole
// pipeline.
//
// Ports
//   aclk, aresetn          clock, asynchronous active-low reset
//   s_axis_*               input stream; tdata = {real, imag}
//   m_axis_*               output stream; tdata = {real, imag} after gain
//   cfg_mode               0 bypass, 1 lowpass, 2 highpass, 3 bandpass
//   cfg_r_lo / cfg_r_hi    squared-radius thresholds
//   cfg_gain_pass / _stop  signed Q1.(GAIN_W-1) gains
//   err_tlast              sticky flag for a tlast/position disagreement
//   frame_cnt              completed frames (wraps)
//   dbg_row_cnt/col_cnt    position counters of the next input pixel
//   dbg_dist               squared distance of that position
// ---------------------------------------------------------------------------
module freq_filter_mul #(
    parameter int ROW_BITS = 7,
    parameter int COL_BITS = 7,
    parameter int COMP_W   = 32,
    parameter int GAIN_W   = 16,
    parameter int DIST_W   = 2 * ((ROW_BITS > COL_BITS) ? ROW_BITS : COL_BITS)
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [2*COMP_W-1:0]   s_axis_tdata,
    input  logic                  s_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [2*COMP_W-1:0]   m_axis_tdata,
    output logic                  m_axis_tlast,
    input  logic [1:0]            cfg_mode,
    input  logic [DIST_W-1:0]     cfg_r_lo,
    input  logic [DIST_W-1:0]     cfg_r_hi,
    input  logic [GAIN_W-1:0]     cfg_gain_pass,
    input  logic [GAIN_W-1:0]     cfg_gain_stop,
    output logic                  err_tlast,
    output logic [15:0]           frame_cnt,
    output logic [ROW_BITS-1:0]   dbg_row_cnt,
    output logic [COL_BITS-1:0]   dbg_col_cnt,
    output logic [DIST_W-1:0]     dbg_dist
);

    localparam logic [1:0] MODE_BYPASS   = 2'd0;
    localparam logic [1:0] MODE_LOWPASS  = 2'd1;
    localparam logic [1:0] MODE_HIGHPASS = 2'd2;
    localparam logic [1:0] MODE_BANDPASS = 2'd3;

    localparam int PROD_W = COMP_W + GAIN_W;

    localparam logic [ROW_BITS-1:0] ROW_HALF = ROW_BITS'(1) << (ROW_BITS - 1);
    localparam logic [COL_BITS-1:0] COL_HALF = COL_BITS'(1) << (COL_BITS - 1);
    localparam logic [ROW_BITS-1:0] ROW_LAST = '1;
    localparam logic [COL_BITS-1:0] COL_LAST = '1;

    // The offsets from the centre are at most H/2 and W/2. The squares and
    // their sum therefore fit in DIST_W bits, so the plain DIST_W product is exact.
    function automatic logic [DIST_W-1:0] sqDist(input logic [ROW_BITS-1:0] rowAbs,
                                                 input logic [COL_BITS-1:0] colAbs);
        logic [DIST_W-1:0] rw;
        logic [DIST_W-1:0] cw;
        rw = DIST_W'(rowAbs);
        cw = DIST_W'(colAbs);
        return rw * rw + cw * cw;
    endfunction

    // The product is floored by the arithmetic shift. It fits in COMP_W bits
    // only when every bit from the result sign upward is the same.
    function automatic logic [COMP_W-1:0] scaleSat(input logic signed [COMP_W-1:0] comp,
                                                   input logic signed [GAIN_W-1:0] gain);
        logic signed [PROD_W-1:0] prod;
        logic signed [PROD_W-1:0] shifted;
        prod    = PROD_W'(comp) * PROD_W'(gain);
        shifted = prod >>> (GAIN_W - 1);
        if ((&shifted[PROD_W-1:COMP_W-1]) || !(|shifted[PROD_W-1:COMP_W-1]))
            return shifted[COMP_W-1:0];
        else if (shifted[PROD_W-1])
            return {1'b1, {(COMP_W-1){1'b0}}};
        else
            return {1'b0, {(COMP_W-1){1'b1}}};
    endfunction

    logic                  advance;
    logic                  inFire;
    logic                  atOrigin;
    logic                  atEnd;

    logic [ROW_BITS-1:0]   rowCnt_q, rowCnt_d;
    logic [COL_BITS-1:0]   colCnt_q, colCnt_d;
    logic [15:0]           frameCnt_q, frameCnt_d;
    logic                  errTlast_q, errTlast_d;

    logic [1:0]            shadowMode_q;
    logic [DIST_W-1:0]     shadowRLo_q, shadowRHi_q;
    logic [GAIN_W-1:0]     shadowPass_q, shadowStop_q;

    logic [1:0]            effMode;
    logic [DIST_W-1:0]     effRLo, effRHi;
    logic [GAIN_W-1:0]     effPass, effStop;
    logic [ROW_BITS-1:0]   rowAbs;
    logic [COL_BITS-1:0]   colAbs;

    logic                  s1Valid_q, s1Last_q;
    logic [2*COMP_W-1:0]   s1Data_q;
    logic [ROW_BITS-1:0]   s1RowAbs_q;
    logic [COL_BITS-1:0]   s1ColAbs_q;
    logic [1:0]            s1Mode_q;
    logic [DIST_W-1:0]     s1RLo_q, s1RHi_q;
    logic [GAIN_W-1:0]     s1Pass_q, s1Stop_q;

    logic [DIST_W-1:0]     s1Dist;
    logic                  usePass;

    logic                  s2Valid_q, s2Last_q, s2Bypass_q;
    logic [2*COMP_W-1:0]   s2Data_q;
    logic [GAIN_W-1:0]     s2Gain_q;

    logic                  outValid_q, outLast_q;
    logic [2*COMP_W-1:0]   outData_q, outData_d;

    // The whole pipeline moves only when the output register can be
    // overwritten. That single enable gives the stall behaviour and
    // prevents any beat from being dropped or duplicated.
    assign advance  = m_axis_tready | ~outValid_q;
    assign inFire   = s_axis_tvalid & advance;
    assign atOrigin = (rowCnt_q == '0) && (colCnt_q == '0);
    assign atEnd    = (rowCnt_q == ROW_LAST) && (colCnt_q == COL_LAST);

    // Offsets use counter - half when the counter MSB is set, else half - counter.
    assign rowAbs = rowCnt_q[ROW_BITS-1] ? (rowCnt_q - ROW_HALF) : (ROW_HALF - rowCnt_q);
    assign colAbs = colCnt_q[COL_BITS-1] ? (colCnt_q - COL_HALF) : (COL_HALF - colCnt_q);

    // Pixel (0,0) already uses the live configuration that the shadow is
    // about to capture. Every later pixel in the frame uses the shadow.
    assign effMode = atOrigin ? cfg_mode      : shadowMode_q;
    assign effRLo  = atOrigin ? cfg_r_lo      : shadowRLo_q;
    assign effRHi  = atOrigin ? cfg_r_hi      : shadowRHi_q;
    assign effPass = atOrigin ? cfg_gain_pass : shadowPass_q;
    assign effStop = atOrigin ? cfg_gain_stop : shadowStop_q;

    // Position tracking. A tlast always resyncs the counters to (0,0), as
    // does reaching the last pixel. A disagreement between tlast and the
    // last-pixel position raises the sticky error flag.
    always_comb begin
        rowCnt_d   = rowCnt_q;
        colCnt_d   = colCnt_q;
        frameCnt_d = frameCnt_q;
        errTlast_d = errTlast_q;
        if (inFire) begin
            if (s_axis_tlast != atEnd)
                errTlast_d = 1'b1;
            if (s_axis_tlast || atEnd) begin
                rowCnt_d   = '0;
                colCnt_d   = '0;
                frameCnt_d = frameCnt_q + 16'd1;
            end else if (colCnt_q == COL_LAST) begin
                colCnt_d = '0;
                rowCnt_d = rowCnt_q + ROW_BITS'(1);
            end else begin
                colCnt_d = colCnt_q + COL_BITS'(1);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rowCnt_q     <= '0;
            colCnt_q     <= '0;
            frameCnt_q   <= '0;
            errTlast_q   <= 1'b0;
            shadowMode_q <= MODE_BYPASS;
            shadowRLo_q  <= '0;
            shadowRHi_q  <= '0;
            shadowPass_q <= '0;
            shadowStop_q <= '0;
        end else begin
            rowCnt_q   <= rowCnt_d;
            colCnt_q   <= colCnt_d;
            frameCnt_q <= frameCnt_d;
            errTlast_q <= errTlast_d;
            if (inFire && atOrigin) begin
                shadowMode_q <= cfg_mode;
                shadowRLo_q  <= cfg_r_lo;
                shadowRHi_q  <= cfg_r_hi;
                shadowPass_q <= cfg_gain_pass;
                shadowStop_q <= cfg_gain_stop;
            end
        end
    end

    // Stage 1: this register captures the beat with its centre offsets and
    // the configuration that applies to its frame.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s1Valid_q  <= 1'b0;
            s1Last_q   <= 1'b0;
            s1Data_q   <= '0;
            s1RowAbs_q <= '0;
            s1ColAbs_q <= '0;
            s1Mode_q   <= MODE_BYPASS;
            s1RLo_q    <= '0;
            s1RHi_q    <= '0;
            s1Pass_q   <= '0;
            s1Stop_q   <= '0;
        end else if (advance) begin
            s1Valid_q  <= s_axis_tvalid;
            s1Last_q   <= s_axis_tlast;
            s1Data_q   <= s_axis_tdata;
            s1RowAbs_q <= rowAbs;
            s1ColAbs_q <= colAbs;
            s1Mode_q   <= effMode;
            s1RLo_q    <= effRLo;
            s1RHi_q    <= effRHi;
            s1Pass_q   <= effPass;
            s1Stop_q   <= effStop;
        end
    end

    assign s1Dist = sqDist(s1RowAbs_q, s1ColAbs_q);

    // The radius thresholds are inclusive at both ends.
    always_comb begin
        usePass = 1'b1;
        case (s1Mode_q)
            MODE_LOWPASS:  usePass = (s1Dist <= s1RHi_q);
            MODE_HIGHPASS: usePass = (s1Dist >= s1RLo_q);
            MODE_BANDPASS: usePass = (s1Dist >= s1RLo_q) && (s1Dist <= s1RHi_q);
            default:       usePass = 1'b1;
        endcase
    end

    // Stage 2: this register holds the selected gain. It also keeps a bypass
    // flag, because unity gain cannot be represented in Q1.(GAIN_W-1).
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s2Valid_q  <= 1'b0;
            s2Last_q   <= 1'b0;
            s2Bypass_q <= 1'b1;
            s2Data_q   <= '0;
            s2Gain_q   <= '0;
        end else if (advance) begin
            s2Valid_q  <= s1Valid_q;
            s2Last_q   <= s1Last_q;
            s2Bypass_q <= (s1Mode_q == MODE_BYPASS);
            s2Data_q   <= s1Data_q;
            s2Gain_q   <= usePass ? s1Pass_q : s1Stop_q;
        end
    end

    always_comb begin
        outData_d = s2Data_q;
        if (!s2Bypass_q)
            outData_d = {scaleSat(s2Data_q[2*COMP_W-1:COMP_W], s2Gain_q),
                         scaleSat(s2Data_q[COMP_W-1:0], s2Gain_q)};
    end

    // Stage 3: the output register. It holds its contents while the
    // downstream side stalls.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            outValid_q <= 1'b0;
            outLast_q  <= 1'b0;
            outData_q  <= '0;
        end else if (advance) begin
            outValid_q <= s2Valid_q;
            outLast_q  <= s2Last_q;
            outData_q  <= outData_d;
        end
    end

    assign s_axis_tready = advance;
    assign m_axis_tvalid = outValid_q;
    assign m_axis_tdata  = outData_q;
    assign m_axis_tlast  = outLast_q;
    assign err_tlast     = errTlast_q;
    assign frame_cnt     = frameCnt_q;
    assign dbg_row_cnt   = rowCnt_q;
    assign dbg_col_cnt   = colCnt_q;
    assign dbg_dist      = sqDist(rowAbs, colAbs);

endmodule

// File: tb/tb_freq_filter_mul.sv
// ---------------------------------------------------------------------------
// tb_freq_filter_mul
//
// Testbench for freq_filter_mul with a scoreboard. Each accepted input beat
// runs through a small reference model that tracks position, per-frame
// configuration, distance, gain and saturation. The model pushes the
// expected output into a queue. The output monitor pops one entry on each
// output handshake and compares it with the DUT output.
// ---------------------------------------------------------------------------
module tb_freq_filter_mul;

    localparam int ROW_BITS = 7;
    localparam int COL_BITS = 7;
    localparam int COMP_W   = 32;
    localparam int GAIN_W   = 16;
    localparam int DIST_W   = 14;
    localparam int H        = 128;
    localparam int W        = 128;

    logic                 aclk = 1'b0;
    logic                 aresetn = 1'b0;
    logic                 s_valid;
    logic                 s_ready;
    logic [2*COMP_W-1:0]  s_data;
    logic                 s_last;
    logic                 m_valid;
    logic                 m_ready = 1'b1;
    logic [2*COMP_W-1:0]  m_data;
    logic                 m_last;
    logic [1:0]           cfg_mode;
    logic [DIST_W-1:0]    cfg_r_lo;
    logic [DIST_W-1:0]    cfg_r_hi;
    logic [GAIN_W-1:0]    cfg_gain_pass;
    logic [GAIN_W-1:0]    cfg_gain_stop;
    logic                 err_tlast;
    logic [15:0]          frame_cnt;
    logic [ROW_BITS-1:0]  dbg_row_cnt;
    logic [COL_BITS-1:0]  dbg_col_cnt;
    logic [DIST_W-1:0]    dbg_dist;

    always #5 aclk = ~aclk;

    freq_filter_mul #(
        .ROW_BITS(ROW_BITS),
        .COL_BITS(COL_BITS),
        .COMP_W(COMP_W),
        .GAIN_W(GAIN_W),
        .DIST_W(DIST_W)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .s_axis_tvalid(s_valid),
        .s_axis_tready(s_ready),
        .s_axis_tdata(s_data),
        .s_axis_tlast(s_last),
        .m_axis_tvalid(m_valid),
        .m_axis_tready(m_ready),
        .m_axis_tdata(m_data),
        .m_axis_tlast(m_last),
        .cfg_mode(cfg_mode),
        .cfg_r_lo(cfg_r_lo),
        .cfg_r_hi(cfg_r_hi),
        .cfg_gain_pass(cfg_gain_pass),
        .cfg_gain_stop(cfg_gain_stop),
        .err_tlast(err_tlast),
        .frame_cnt(frame_cnt),
        .dbg_row_cnt(dbg_row_cnt),
        .dbg_col_cnt(dbg_col_cnt),
        .dbg_dist(dbg_dist)
    );

    typedef struct {
        logic [63:0] data;
        logic        last;
    } sbEntry_t;

    sbEntry_t sb[$];
    sbEntry_t monEntry;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          mRow = 0;
    int          mCol = 0;
    int          mFrames = 0;
    logic        mErr = 1'b0;
    logic [1:0]  mMode = 2'd0;
    int          mRLo = 0;
    int          mRHi = 0;
    logic [15:0] mPass = 16'h0;
    logic [15:0] mStop = 16'h0;

    // 0: always ready, 1: random ready, 2: ready held low
    int readyMode = 0;
    int outCount = 0;
    int lastCount = 0;

    logic [63:0] heldData;
    logic        heldLast;
    bit          heldValid = 0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int modelDist(input int r, input int c);
        return (r - H / 2) * (r - H / 2) + (c - W / 2) * (c - W / 2);
    endfunction

    function automatic logic [31:0] modelScale(input logic [31:0] c, input logic [15:0] g);
        logic signed [47:0] p;
        p = $signed(c) * $signed(g);
        p = p >>> 15;
        if (p > 48'sd2147483647)
            return 32'h7FFFFFFF;
        if (p < -48'sd2147483648)
            return 32'h80000000;
        return p[31:0];
    endfunction

    task automatic modelBeat(input logic [63:0] data, input logic last, output sbEntry_t e);
        int d;
        logic pass;
        logic [15:0] g;
        bit atEnd;
        if (mRow == 0 && mCol == 0) begin
            mMode = cfg_mode;
            mRLo  = int'(cfg_r_lo);
            mRHi  = int'(cfg_r_hi);
            mPass = cfg_gain_pass;
            mStop = cfg_gain_stop;
        end
        d = modelDist(mRow, mCol);
        case (mMode)
            2'd1:    pass = (d <= mRHi);
            2'd2:    pass = (d >= mRLo);
            2'd3:    pass = (d >= mRLo) && (d <= mRHi);
            default: pass = 1'b1;
        endcase
        g = pass ? mPass : mStop;
        e.data = (mMode == 2'd0) ? data : {modelScale(data[63:32], g), modelScale(data[31:0], g)};
        e.last = last;
        atEnd = (mRow == H - 1) && (mCol == W - 1);
        if (last != atEnd)
            mErr = 1'b1;
        if (last || atEnd) begin
            mRow = 0;
            mCol = 0;
            mFrames = (mFrames + 1) % 65536;
        end else if (mCol == W - 1) begin
            mCol = 0;
            mRow++;
        end else begin
            mCol++;
        end
    endtask

    // Drive one beat. The expected value is pushed once the beat is known
    // to be accepted at the coming edge.
    task automatic applyStimulus(input logic [63:0] data, input logic last);
        sbEntry_t e;
        bit sent;
        int waits;
        sent = 0;
        waits = 0;
        @(negedge aclk);
        s_valid = 1'b1;
        s_data  = data;
        s_last  = last;
        while (!sent) begin
            #2;
            if (s_ready) begin
                modelBeat(data, last, e);
                sb.push_back(e);
                @(posedge aclk);
                #1;
                s_valid = 1'b0;
                sent = 1;
            end else if (waits >= 200) begin
                checkOutput("input_timeout", 64'd0, 64'd1);
                s_valid = 1'b0;
                sent = 1;
            end else begin
                waits++;
                @(negedge aclk);
            end
        end
    endtask

    task automatic measureLatency(input logic [63:0] data);
        sbEntry_t e;
        int edges;
        @(negedge aclk);
        s_valid = 1'b1;
        s_data  = data;
        s_last  = 1'b0;
        #2;
        checkOutput("lat_ready", 64'(s_ready), 64'd1);
        modelBeat(data, 1'b0, e);
        sb.push_back(e);
        @(posedge aclk);
        #1;
        s_valid = 1'b0;
        edges = 1;
        while (!m_valid && edges < 10) begin
            @(posedge aclk);
            #1;
            edges++;
        end
        checkOutput("latency", 64'(edges), 64'd3);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(negedge aclk);
            n++;
        end
        repeat (3) @(negedge aclk);
        checkOutput("drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic doReset();
        @(negedge aclk);
        aresetn = 1'b0;
        s_valid = 1'b0;
        sb.delete();
        mRow = 0;
        mCol = 0;
        mFrames = 0;
        mErr = 1'b0;
        #1;
        checkOutput("rst_m_valid", 64'(m_valid), 64'd0);
        checkOutput("rst_m_last", 64'(m_last), 64'd0);
        checkOutput("rst_m_data", m_data, 64'd0);
        checkOutput("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        checkOutput("rst_err", 64'(err_tlast), 64'd0);
        checkOutput("rst_row", 64'(dbg_row_cnt), 64'd0);
        checkOutput("rst_col", 64'(dbg_col_cnt), 64'd0);
        checkOutput("rst_dist", 64'(dbg_dist), 64'(modelDist(0, 0)));
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
    endtask

    // Ready generator and output monitor. The monitor samples just after the
    // falling edge, so a handshake seen here completes at the next rising edge.
    always begin
        @(negedge aclk);
        case (readyMode)
            0:       m_ready = 1'b1;
            1:       m_ready = ($urandom_range(0, 3) != 0);
            default: m_ready = 1'b0;
        endcase
        #1;
        if (!aresetn) begin
            heldValid = 0;
        end else begin
            if (heldValid) begin
                checkOutput("hold_valid", 64'(m_valid), 64'd1);
                checkOutput("hold_data", m_data, heldData);
                checkOutput("hold_last", 64'(m_last), 64'(heldLast));
            end
            heldValid = 0;
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("extra_beat", 64'd1, 64'd0);
                end else begin
                    monEntry = sb.pop_front();
                    checkOutput("out_data", m_data, monEntry.data);
                    checkOutput("out_last", 64'(m_last), 64'(monEntry.last));
                end
                outCount++;
                if (m_last)
                    lastCount++;
            end else if (m_valid) begin
                heldValid = 1;
                heldData  = m_data;
                heldLast  = m_last;
            end
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        logic [63:0] d;
        s_valid       = 1'b0;
        s_data        = '0;
        s_last        = 1'b0;
        cfg_mode      = 2'd0;
        cfg_r_lo      = '0;
        cfg_r_hi      = '0;
        cfg_gain_pass = '0;
        cfg_gain_stop = '0;
        readyMode     = 0;
        doReset();

        // Frame A: a full lowpass frame under random backpressure. The
        // configuration changes mid-frame, and that change must wait for the next frame.
        cfg_mode      = 2'd1;
        cfg_r_lo      = 14'd256;
        cfg_r_hi      = 14'd1024;
        cfg_gain_pass = 16'h4000;
        cfg_gain_stop = 16'h0000;
        readyMode     = 1;
        outCount      = 0;
        lastCount     = 0;
        for (int i = 0; i < H * W; i++) begin
            if (i == 0 || i == (64 * W + 64) || i == (32 * W + 32))
                d = 64'h00010000_00010000;
            else
                d = {$urandom, $urandom};
            if (i == 5000) begin
                cfg_mode      = 2'd3;
                cfg_r_lo      = 14'd8000;
                cfg_r_hi      = 14'd16383;
                cfg_gain_pass = 16'h8000;
                cfg_gain_stop = 16'h1234;
            end
            if ($urandom_range(0, 9) == 0)
                @(negedge aclk);
            applyStimulus(d, i == H * W - 1);
        end
        drain();
        checkOutput("frameA_outputs", 64'(outCount), 64'(H * W));
        checkOutput("frameA_tlasts", 64'(lastCount), 64'd1);
        checkOutput("frameA_frame_cnt", 64'(frame_cnt), 64'(mFrames));
        checkOutput("frameA_err", 64'(err_tlast), 64'(mErr));
        $display("[TB] frame A complete");

        // Frame B: bandpass with a -1.0 pass gain, including a saturation
        // case. tlast arrives early at (0,10).
        for (int i = 0; i <= 10; i++) begin
            if (i == 0)
                d = 64'h80000000_00000001;
            else
                d = {$urandom, $urandom};
            applyStimulus(d, i == 10);
        end
        drain();
        checkOutput("frameB_err", 64'(err_tlast), 64'(mErr));
        checkOutput("frameB_frame_cnt", 64'(frame_cnt), 64'(mFrames));
        checkOutput("frameB_row", 64'(dbg_row_cnt), 64'd0);
        checkOutput("frameB_col", 64'(dbg_col_cnt), 64'd0);
        checkOutput("frameB_dist", 64'(dbg_dist), 64'(modelDist(0, 0)));

        // Frame C: bypass mode with a latency measurement and position checks.
        readyMode = 0;
        cfg_mode  = 2'd0;
        measureLatency({$urandom, $urandom});
        applyStimulus({$urandom, $urandom}, 1'b0);
        applyStimulus({$urandom, $urandom}, 1'b0);
        drain();
        checkOutput("frameC_row", 64'(dbg_row_cnt), 64'(mRow));
        checkOutput("frameC_col", 64'(dbg_col_cnt), 64'(mCol));
        checkOutput("frameC_dist", 64'(dbg_dist), 64'(modelDist(mRow, mCol)));

        // Reset in the middle of a frame while beats are stalled in the
        // pipeline. After release the frame restarts at pixel (0,0).
        cfg_mode      = 2'd2;
        cfg_r_lo      = 14'd100;
        cfg_gain_pass = 16'h2000;
        cfg_gain_stop = 16'h7FFF;
        readyMode     = 2;
        applyStimulus({$urandom, $urandom}, 1'b0);
        applyStimulus({$urandom, $urandom}, 1'b0);
        repeat (4) @(negedge aclk);
        doReset();
        readyMode = 1;
        for (int i = 0; i < 4; i++)
            applyStimulus({$urandom, $urandom}, 1'b0);
        drain();
        checkOutput("post_rst_frame_cnt", 64'(frame_cnt), 64'(mFrames));
        checkOutput("post_rst_err", 64'(err_tlast), 64'(mErr));
        checkOutput("post_rst_col", 64'(dbg_col_cnt), 64'(mCol));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/freq_filter_mul.md
FREQ_FILTER_MUL -- requirements
Module: freq_filter_mul

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- ROW_BITS, 7, log2 frame height; frame height H = 2^ROW_BITS.
- COL_BITS, 7, log2 frame width; frame width W = 2^COL_BITS.
- COMP_W, 32, width of each signed fixed-point component (real, imag).
- GAIN_W, 16, signed gain width, Q1.(GAIN_W-1) format.
- DIST_W, 2*max(ROW_BITS,COL_BITS), squared-radius width.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- aclk, in, 1, sole clock.
- aresetn, in, 1, asynchronous active-low reset.
- s_axis_tvalid, in, 1, input beat valid.
- s_axis_tready, out, 1, input accept.
- s_axis_tdata, in, 2*COMP_W, {real, imag}.
- s_axis_tlast, in, 1, last pixel of frame.
- m_axis_tvalid, out, 1, output beat valid.
- m_axis_tready, in, 1, downstream accept.
- m_axis_tdata, out, 2*COMP_W, {real, imag} after gain.
- m_axis_tlast, out, 1, tlast delayed with its beat.
- cfg_mode, in, 2, 0 bypass, 1 lowpass, 2 highpass, 3 bandpass.
- cfg_r_lo, in, DIST_W, lower squared-radius threshold.
- cfg_r_hi, in, DIST_W, upper squared-radius threshold.
- cfg_gain_pass, in, GAIN_W, passband gain.
- cfg_gain_stop, in, GAIN_W, stopband gain.
- err_tlast, out, 1, sticky tlast-misalignment flag.
- frame_cnt, out, 16, completed frames, wraps at 2^16.
- dbg_row_cnt, out, ROW_BITS, current row counter.
- dbg_col_cnt, out, COL_BITS, current column counter.
- dbg_dist, out, DIST_W, squared distance of the counter position.

Function
REQ-003 The pixel position SHALL advance on each input handshake: col increments; at W-1 col wraps to 0 and row increments; at (H-1,W-1) both wrap to 0 and frame_cnt increments.
REQ-004 Distance SHALL be d = (row-H/2)^2 + (col-W/2)^2, unsigned, exact within DIST_W bits; dbg_dist SHALL be combinational from the current counters.
REQ-005 Gain select: bypass -> pass; lowpass -> pass if d<=r_hi, else stop; highpass -> pass if d>=r_lo, else stop; bandpass -> pass if r_lo<=d<=r_hi, else stop.
REQ-006 Configuration SHALL be shadowed on the handshake of pixel (0,0) and held for the whole frame; mid-frame cfg changes SHALL NOT affect the current frame.
REQ-007 Each component SHALL be (comp*gain) arithmetically shifted right by GAIN_W-1 (floor), then saturated to [-2^(COMP_W-1), 2^(COMP_W-1)-1].
REQ-008 Bypass SHALL pass data unmodified through the same pipeline (identical latency).
REQ-009 Pipeline: 3 registered stages (position/delta, distance/gain select, multiply/saturate); latency SHALL be exactly 3 cycles from input handshake to m_axis_tvalid when m_axis_tready=1.
REQ-010 Throughput SHALL be one beat per cycle; s_axis_tready = m_axis_tready OR NOT m_axis_tvalid; all stages SHALL hold while m_axis_tvalid=1 and m_axis_tready=0, with m_axis_tdata/tlast stable.
REQ-011 No beat SHALL be dropped or duplicated under any tready pattern.
REQ-012 tlast on a pixel other than (H-1,W-1), or its absence on (H-1,W-1), SHALL set err_tlast; on any accepted tlast the counters SHALL resync to (0,0) and frame_cnt SHALL increment.
REQ-013 m_axis_tlast SHALL be the input tlast delayed with its beat, not regenerated.

Reset
REQ-014 On aresetn=0, asynchronously: all stage valids, m_axis_tvalid, m_axis_tlast, err_tlast, frame_cnt, row/col counters = 0; m_axis_tdata = 0; shadow cfg = bypass, gains 0.
REQ-015 Reset mid-frame SHALL discard in-flight beats; first beat after release is pixel (0,0).

Verification
REQ-016 Lowpass, r_hi=1024, pass=0x4000, stop=0; input {0x00010000,0x00010000} at (64,64) -> dist 0, output {0x00008000,0x00008000} after 3 cycles.
REQ-017 Same cfg, pixel (32,32) -> dist 2048, output {0,0}; pixel (0,0) -> dist 8192, output {0,0}.
REQ-018 pass=0x8000 (-1.0), input real 0x80000000 -> saturated real 0x7FFFFFFF; imag 0x00000001 -> 0xFFFFFFFF.
REQ-019 Full 16384-beat frame with random m_axis_tready -> 16384 outputs in order, single m_axis_tlast on last, frame_cnt=1, err_tlast=0.
REQ-020 tlast at pixel (0,10) -> err_tlast=1, next beat at (0,0), frame_cnt increments.
REQ-021 cfg_mode changed mid-frame -> current frame unchanged; new mode applied from next (0,0).
